// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants for the 8-entry FIFO (controller state
// encoding, depth and pointer/count widths).
package fifo_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int PTR_W      = 3;
  localparam int CNT_W      = 4;

  localparam logic [2:0] INIT   = 3'b000;
  localparam logic [2:0] WRITE  = 3'b001;
  localparam logic [2:0] WR_ERR = 3'b010;
  localparam logic [2:0] NO_OP  = 3'b011;
  localparam logic [2:0] READ   = 3'b100;
  localparam logic [2:0] RD_ERR = 3'b101;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

endpackage

// File: rtl/fifo_err_counter.sv
// fifo_err_counter: 8-bit saturating event counter.
// Ports: clk, rst (async high), i_inc strobe, o_cnt count.
module fifo_err_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  output logic [7:0] o_cnt
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (i_inc && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fifo_cal.sv
// fifo_cal: combinational next-state calculator for the 8-entry FIFO,
// plus error statistics when FIFO_CAL_ERR_STATS_EN is defined.
// Ports: clk, rst (async high); state, head, tail, data_count in;
// we, re, next_head, next_tail, next_data_count,
// wr_err_cnt, rd_err_cnt out (counters tie to 0 without the macro).
module fifo_cal
  import fifo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       state,
  input  logic [PTR_W-1:0] head,
  input  logic [PTR_W-1:0] tail,
  input  logic [CNT_W-1:0] data_count,
  output logic             we,
  output logic             re,
  output logic [PTR_W-1:0] next_head,
  output logic [PTR_W-1:0] next_tail,
  output logic [CNT_W-1:0] next_data_count,
  output logic [7:0]       wr_err_cnt,
  output logic [7:0]       rd_err_cnt
);

  // Counts of 9..15 fall into the full branch too.
  logic w_full;
  logic w_empty;

  assign w_full  = (data_count >= CNT_FULL);
  assign w_empty = (data_count == '0);

  always_comb begin
    we              = 1'b0;
    re              = 1'b0;
    next_head       = head;
    next_tail       = tail;
    next_data_count = data_count;
    unique case (state)
      INIT: begin
        next_head       = '0;
        next_tail       = '0;
        next_data_count = '0;
      end
      WRITE: begin
        if (!w_full) begin
          we              = 1'b1;
          next_tail       = tail + 3'd1;
          next_data_count = data_count + 4'd1;
        end
      end
      READ: begin
        if (!w_empty) begin
          re              = 1'b1;
          next_head       = head + 3'd1;
          next_data_count = data_count - 4'd1;
        end
      end
      default: begin
      end
    endcase
  end

`ifdef FIFO_CAL_ERR_STATS_EN
  logic w_wr_err;
  logic w_rd_err;

  assign w_wr_err = (state == WR_ERR);
  assign w_rd_err = (state == RD_ERR);

  fifo_err_counter u_wr_err (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_wr_err),
    .o_cnt (wr_err_cnt)
  );

  fifo_err_counter u_rd_err (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_rd_err),
    .o_cnt (rd_err_cnt)
  );
`else
  // clk/rst only feed the statistics; keep them referenced.
  logic w_unused;
  assign w_unused   = clk ^ rst;
  assign wr_err_cnt = 8'd0;
  assign rd_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_cal.sv
// tb_fifo_cal: scoreboard bench for fifo_cal.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_fifo_cal;
  import fifo_pkg::*;

`ifdef FIFO_CAL_ERR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] state;
  logic [2:0] head;
  logic [2:0] tail;
  logic [3:0] data_count;
  logic       we;
  logic       re;
  logic [2:0] next_head;
  logic [2:0] next_tail;
  logic [3:0] next_data_count;
  logic [7:0] wr_err_cnt;
  logic [7:0] rd_err_cnt;

  fifo_cal dut (
    .clk             (clk),
    .rst             (rst),
    .state           (state),
    .head            (head),
    .tail            (tail),
    .data_count      (data_count),
    .we              (we),
    .re              (re),
    .next_head       (next_head),
    .next_tail       (next_tail),
    .next_data_count (next_data_count),
    .wr_err_cnt      (wr_err_cnt),
    .rd_err_cnt      (rd_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         kind;
    string      name;
    logic       we;
    logic       re;
    logic [2:0] nh;
    logic [2:0] nt;
    logic [3:0] nc;
    logic [7:0] wc;
    logic [7:0] rc;
  } exp_t;

  exp_t q[$];
  bit   pend;
  int   total;
  int   bad;

  task automatic chk(input string nm, input string fld,
                     input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      pend = 1'b0;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow got=0 want=1");
      end else begin
        e = q.pop_front();
        if (e.kind == 1'b0) begin
          chk(e.name, "we", {7'd0, we}, {7'd0, e.we});
          chk(e.name, "re", {7'd0, re}, {7'd0, e.re});
          chk(e.name, "nh", {5'd0, next_head}, {5'd0, e.nh});
          chk(e.name, "nt", {5'd0, next_tail}, {5'd0, e.nt});
          chk(e.name, "nc", {4'd0, next_data_count}, {4'd0, e.nc});
        end else begin
          chk(e.name, "wr", wr_err_cnt, e.wc);
          chk(e.name, "rd", rd_err_cnt, e.rc);
        end
      end
    end
  end

  task automatic vec(input string nm, input logic [2:0] st,
                     input logic [2:0] h, input logic [2:0] t,
                     input logic [3:0] c, input logic ewe,
                     input logic ere, input logic [2:0] enh,
                     input logic [2:0] ent, input logic [3:0] enc);
    exp_t e;
    @(posedge clk);
    #1;
    state      = st;
    head       = h;
    tail       = t;
    data_count = c;
    e.kind = 1'b0;
    e.name = nm;
    e.we   = ewe;
    e.re   = ere;
    e.nh   = enh;
    e.nt   = ent;
    e.nc   = enc;
    e.wc   = 8'd0;
    e.rc   = 8'd0;
    q.push_back(e);
    pend = 1'b1;
  endtask

  task automatic cchk(input string nm, input logic [7:0] ewc,
                      input logic [7:0] erc);
    exp_t e;
    e.kind = 1'b1;
    e.name = nm;
    e.we   = 1'b0;
    e.re   = 1'b0;
    e.nh   = 3'd0;
    e.nt   = 3'd0;
    e.nc   = 4'd0;
    e.wc   = STATS ? ewc : 8'd0;
    e.rc   = STATS ? erc : 8'd0;
    q.push_back(e);
    pend = 1'b1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    pend       = 1'b0;
    rst        = 1'b1;
    state      = INIT;
    head       = 3'd0;
    tail       = 3'd0;
    data_count = 4'd0;

    repeat (2) @(posedge clk);
    #1;
    cchk("rst_hold", 8'd0, 8'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cchk("post_rst", 8'd0, 8'd0);

    vec("init0",  INIT,   3'd0, 3'd0, 4'd0,  0, 0, 3'd0, 3'd0, 4'd0);
    vec("init1",  INIT,   3'd5, 3'd2, 4'd6,  0, 0, 3'd0, 3'd0, 4'd0);
    vec("wr7",    WRITE,  3'd1, 3'd3, 4'd7,  1, 0, 3'd1, 3'd4, 4'd8);
    vec("wrwrap", WRITE,  3'd2, 3'd7, 4'd5,  1, 0, 3'd2, 3'd0, 4'd6);
    vec("rdwrap", READ,   3'd7, 3'd0, 4'd6,  0, 1, 3'd0, 3'd0, 4'd5);
    vec("wrerr",  WR_ERR, 3'd1, 3'd4, 4'd8,  0, 0, 3'd1, 3'd4, 4'd8);
    vec("wrfull", WRITE,  3'd1, 3'd4, 4'd8,  0, 0, 3'd1, 3'd4, 4'd8);
    vec("rdempt", READ,   3'd1, 3'd4, 4'd0,  0, 0, 3'd1, 3'd4, 4'd0);
    vec("noop",   NO_OP,  3'd1, 3'd4, 4'd8,  0, 0, 3'd1, 3'd4, 4'd8);
    vec("rderr",  RD_ERR, 3'd1, 3'd4, 4'd8,  0, 0, 3'd1, 3'd4, 4'd8);
    vec("ill7",   3'b111, 3'd1, 3'd4, 4'd8,  0, 0, 3'd1, 3'd4, 4'd8);
    vec("ill6",   3'b110, 3'd1, 3'd4, 4'd8,  0, 0, 3'd1, 3'd4, 4'd8);
    vec("wr12",   WRITE,  3'd1, 3'd4, 4'd12, 0, 0, 3'd1, 3'd4, 4'd12);
    vec("wr0",    WRITE,  3'd0, 3'd0, 4'd0,  1, 0, 3'd0, 3'd1, 4'd1);
    vec("rd1",    READ,   3'd3, 3'd5, 4'd1,  0, 1, 3'd4, 3'd5, 4'd0);
    vec("rd8",    READ,   3'd7, 3'd7, 4'd8,  0, 1, 3'd0, 3'd7, 4'd7);

    @(posedge clk);
    #1;
    state = NO_OP;
    rst   = 1'b1;
    #1;
    cchk("rst_clr", 8'd0, 8'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    @(posedge clk);
    #1;
    state = WR_ERR;
    repeat (300) @(posedge clk);
    #1;
    cchk("wr_sat", 8'd255, 8'd0);
    state = RD_ERR;
    repeat (3) @(posedge clk);
    #1;
    cchk("rd_3", 8'd255, 8'd3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    cchk("rst_mid", 8'd0, 8'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cchk("rd_after", 8'd0, 8'd1);
    state = NO_OP;

    @(negedge clk);
    #2;
    if (q.size() != 0 || pend) begin
      total++;
      bad++;
      $display("FAIL sb_left got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
